// File: rtl/ysyx_22040175_pipe_skid_reg_pkg.sv
// Shared definitions for the valid/ready skid pipeline register.
// State is the pair {main_v, skid_v}; 2'b01 cannot occur.
package ysyx_22040175_pipe_skid_reg_pkg;

    typedef logic [1:0] skid_state_t;

    localparam skid_state_t ST_EMPTY = 2'b00;
    localparam skid_state_t ST_BUSY  = 2'b10;
    localparam skid_state_t ST_FULL  = 2'b11;

endpackage

// File: rtl/ysyx_22040175_pipe_skid_reg_sat_cnt.sv
// Saturating up-counter with increment enable; cleared only by reset.
// Used for the stall/bubble counters when PIPE_SKID_PERF_EN is defined.
module ysyx_22040175_sat_cnt
    import ysyx_22040175_pipe_skid_reg_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_22040175_pipe_skid_reg.sv
// Valid/ready pipeline register with a 2-entry skid buffer and flush.
// Perf counters exist only when PIPE_SKID_PERF_EN is defined.
module ysyx_22040175_pipe_skid_reg
    import ysyx_22040175_pipe_skid_reg_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RST_DATA = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic              in_fire;
    logic              out_fire;
    skid_state_t       state;

    // Ready depends only on a flop plus flush, so no comb path from out_ready.
    assign in_ready  = !flush && !skid_v;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_v && out_ready;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign state     = {main_v, skid_v};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= RST_DATA;
            skid_d <= RST_DATA;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_v <= 1'b1;
                        main_d <= in_data;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d <= in_data;
                    end else if (in_fire) begin
                        skid_v <= 1'b1;
                        skid_d <= in_data;
                    end else if (out_fire) begin
                        main_v <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // Skid always holds the younger beat, so it moves up.
                    if (out_fire) begin
                        main_d <= skid_d;
                        skid_v <= 1'b0;
                    end
                end
                default: begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic stall_inc;
    logic bubble_inc;

    assign stall_inc  = main_v && !out_ready;
    assign bubble_inc = !main_v;

    ysyx_22040175_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(stall_inc),
        .cnt(stall_cnt)
    );

    ysyx_22040175_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk(clk),
        .rst(rst),
        .inc(bubble_inc),
        .cnt(bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
